dispense_controller: RTL and testbench

Drives the coin-return ejectors and the water valve. Sits directly downstream of `soda_machine` and turns its single-cycle `pour_water`, `change1`, `change2` and `change22` strobes into timed actuator pulses. Requests are queued in pending counters. Each ejected coin is confirmed by a sensor, and a missing confirmation raises a fault.

---
 rtl/soda_machine_types.sv | 40 ++++
 rtl/dispense_counter.sv | 43 ++++
 rtl/dispense_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_dispense_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soda_machine_types.sv
// Shared types and defaults for the soda machine datapath.
//   insert_type          - coin classification used by soda_machine
//   dispense_state_type  - states of dispense_controller
//   DEFAULT_*            - default timing/width constants for dispense_controller
//   max_of4              - helper used to size the shared dispense timer
package soda_machine_types;

  typedef enum logic [1:0] {
    INSERT_NONE,
    INSERT_COIN1,
    INSERT_COIN2
  } insert_type;

  typedef enum logic [2:0] {
    IDLE,
    EJECT1,
    EJECT2,
    WAIT1,
    WAIT2,
    POUR,
    GAP,
    FAULT
  } dispense_state_type;

  localparam int DEFAULT_PULSE_CYCLES   = 8;
  localparam int DEFAULT_GAP_CYCLES     = 4;
  localparam int DEFAULT_POUR_CYCLES    = 100;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_CNT_W          = 4;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dispense_counter.sv
// Saturating pending-request counter.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   inc [1:0]   - amount to add this cycle (0..3)
//   dec         - subtract one this cycle (applied together with inc)
//   count       - current pending count
//   sat_hit     - high in a cycle whose increment is clipped at full scale
module dispense_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             sat_hit
);

  localparam logic [CNT_W+1:0] SAT = {2'b00, {CNT_W{1'b1}}};
  localparam logic [CNT_W+1:0] ONE = {{(CNT_W+1){1'b0}}, 1'b1};

  // Two spare bits hold the unclipped result so clipping is a simple compare.
  logic [CNT_W+1:0] sum;
  logic [CNT_W+1:0] next;

  always_comb begin
    sum  = {2'b00, count} + {{CNT_W{1'b0}}, inc};
    next = sum;
    if (dec && (sum != '0)) next = sum - ONE;
    sat_hit = (next > SAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (sat_hit) begin
      count <= {CNT_W{1'b1}};
    end else begin
      count <= next[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/dispense_controller.sv
// Turns single-cycle change/pour strobes into timed ejector and valve pulses.
// Requests queue in three saturating counters; each ejected coin must be
// confirmed by its exit sensor or the controller locks up in FAULT.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   pour_water              - one pour request per high cycle
//   change1                 - one 1-coin request per high cycle
//   change2 / change22      - one / two 2-coin requests per high cycle
//   coin1_seen, coin2_seen  - coin exit sensors (one-cycle pulses)
//   eject1, eject2          - coin solenoid drives
//   valve_open              - water valve drive
//   busy                    - not idle or requests still pending
//   fault                   - sticky coin-confirmation timeout
//   overflow                - sticky lost-request flag
//
// state  | meaning
// IDLE   | pick next job: 2-coin, then 1-coin, then pour
// EJECT1 | eject1 on for PULSE_CYCLES
// EJECT2 | eject2 on for PULSE_CYCLES
// WAIT1  | wait up to TIMEOUT_CYCLES for coin1_seen
// WAIT2  | wait up to TIMEOUT_CYCLES for coin2_seen
// POUR   | valve on for POUR_CYCLES
// GAP    | all drives off for GAP_CYCLES
// FAULT  | terminal, left only through reset
import soda_machine_types::*;

module dispense_controller #(
  parameter int PULSE_CYCLES   = DEFAULT_PULSE_CYCLES,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int POUR_CYCLES    = DEFAULT_POUR_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic pour_water,
  input  logic change1,
  input  logic change2,
  input  logic change22,
  input  logic coin1_seen,
  input  logic coin2_seen,
  output logic eject1,
  output logic eject2,
  output logic valve_open,
  output logic busy,
  output logic fault,
  output logic overflow
);

  localparam int TIMER_W = $clog2(max_of4(PULSE_CYCLES, GAP_CYCLES,
                                          POUR_CYCLES, TIMEOUT_CYCLES) + 1);

  // Timer counts down to zero; a state lasting N cycles is loaded with N-1.
  localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] POUR_LOAD  = TIMER_W'(POUR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WAIT_LOAD  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  dispense_state_type state;
  logic [TIMER_W-1:0] timer;

  logic [CNT_W-1:0] pend1;
  logic [CNT_W-1:0] pend2;
  logic [CNT_W-1:0] pend_pour;
  logic             sat1;
  logic             sat2;
  logic             sat_pour;
  logic             dec1;
  logic             dec2;
  logic             dec_pour;

  // A coin is only retired once its sensor confirms it; a pour is retired
  // as soon as the controller commits to it.
  assign dec1     = (state == WAIT1) && coin1_seen;
  assign dec2     = (state == WAIT2) && coin2_seen;
  assign dec_pour = (state == IDLE) && (pend2 == '0) && (pend1 == '0) &&
                    (pend_pour != '0);

  dispense_counter #(.CNT_W(CNT_W)) u_pend1 (
    .clk     (clk),
    .reset   (reset),
    .inc     ({1'b0, change1}),
    .dec     (dec1),
    .count   (pend1),
    .sat_hit (sat1)
  );

  // change2 weighs 1 and change22 weighs 2, so together they add 3.
  dispense_counter #(.CNT_W(CNT_W)) u_pend2 (
    .clk     (clk),
    .reset   (reset),
    .inc     ({change22, change2}),
    .dec     (dec2),
    .count   (pend2),
    .sat_hit (sat2)
  );

  dispense_counter #(.CNT_W(CNT_W)) u_pend_pour (
    .clk     (clk),
    .reset   (reset),
    .inc     ({1'b0, pour_water}),
    .dec     (dec_pour),
    .count   (pend_pour),
    .sat_hit (sat_pour)
  );

  assign busy = (state != IDLE) || (pend1 != '0) || (pend2 != '0) ||
                (pend_pour != '0);

  // Drives are registered alongside the next state so each output is a
  // flop that is high exactly while the matching state is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      eject1     <= 1'b0;
      eject2     <= 1'b0;
      valve_open <= 1'b0;
      fault      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (sat1 || sat2 || sat_pour) overflow <= 1'b1;
      eject1     <= 1'b0;
      eject2     <= 1'b0;
      valve_open <= 1'b0;

      case (state)
        IDLE: begin
          if (pend2 != '0) begin
            state  <= EJECT2;
            timer  <= PULSE_LOAD;
            eject2 <= 1'b1;
          end else if (pend1 != '0) begin
            state  <= EJECT1;
            timer  <= PULSE_LOAD;
            eject1 <= 1'b1;
          end else if (pend_pour != '0) begin
            state      <= POUR;
            timer      <= POUR_LOAD;
            valve_open <= 1'b1;
          end
        end

        EJECT1: begin
          if (timer == '0) begin
            state <= WAIT1;
            timer <= WAIT_LOAD;
          end else begin
            timer  <= timer - TIMER_ONE;
            eject1 <= 1'b1;
          end
        end

        EJECT2: begin
          if (timer == '0) begin
            state <= WAIT2;
            timer <= WAIT_LOAD;
          end else begin
            timer  <= timer - TIMER_ONE;
            eject2 <= 1'b1;
          end
        end

        // Sensor is checked before the timer so a pulse in the final
        // timeout cycle still counts.
        WAIT1: begin
          if (coin1_seen) begin
            state <= GAP;
            timer <= GAP_LOAD;
          end else if (timer == '0) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end

        WAIT2: begin
          if (coin2_seen) begin
            state <= GAP;
            timer <= GAP_LOAD;
          end else if (timer == '0) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end

        POUR: begin
          if (timer == '0) begin
            state <= GAP;
            timer <= GAP_LOAD;
          end else begin
            timer      <= timer - TIMER_ONE;
            valve_open <= 1'b1;
          end
        end

        GAP: begin
          if (timer == '0) begin
            state <= IDLE;
          end else begin
            timer <= timer - TIMER_ONE;
          end
        end

        FAULT: begin
          fault <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispense_controller.sv
module tb_dispense_controller;

  logic clk = 1'b0;
  logic reset;
  logic pour_water, change1, change2, change22, coin1_seen, coin2_seen;
  logic eject1, eject2, valve_open, busy, fault, overflow;

  int checks = 0;
  int errors = 0;

  dispense_controller dut (
    .clk        (clk),
    .reset      (reset),
    .pour_water (pour_water),
    .change1    (change1),
    .change2    (change2),
    .change22   (change22),
    .coin1_seen (coin1_seen),
    .coin2_seen (coin2_seen),
    .eject1     (eject1),
    .eject2     (eject2),
    .valve_open (valve_open),
    .busy       (busy),
    .fault      (fault),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // input vector bits: {reset, pour_water, change1, change2, change22, coin1_seen, coin2_seen}
  // output vector bits: {eject1, eject2, valve_open, busy, fault, overflow}
  typedef struct {
    logic [6:0] in;
    logic [5:0] exp;
  } vec_t;

  vec_t tv [19];

  localparam logic [6:0] IN_RST  = 7'b1000000;
  localparam logic [6:0] IN_POUR = 7'b0100000;
  localparam logic [6:0] IN_C1   = 7'b0010000;
  localparam logic [6:0] IN_C2   = 7'b0001000;
  localparam logic [6:0] IN_S1   = 7'b0000010;
  localparam logic [6:0] IN_S2   = 7'b0000001;
  localparam logic [6:0] IN_NONE = 7'b0000000;

  function automatic logic [5:0] outs();
    return {eject1, eject2, valve_open, busy, fault, overflow};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b (e1 e2 valve busy fault ovf)", name, got, exp);
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs are
  // sampled on the falling edge of the same cycle.
  task automatic step(input logic [6:0] in);
    @(posedge clk);
    #1;
    {reset, pour_water, change1, change2, change22, coin1_seen, coin2_seen} = in;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(IN_RST);
    step(IN_RST);
  endtask

  // Run statistics; drive index 2=eject1, 1=eject2, 0=valve_open.
  int st_pulses [3];
  int st_min [3];
  int st_max [3];
  logic [2:0] st_first;
  int st_last_eject;
  int st_first_valve;
  logic st_overlap;
  logic st_fault;
  logic run_done;

  // Applies strobes from cycle 0, confirms each ejected coin 'delay' cycles
  // after its pulse ends, and runs until busy drops or the budget expires.
  task automatic run_seq(input int n_c1, input logic c2_0, input logic c22_0,
                         input logic pw_0, input int delay, input int budget);
    int c;
    int c1_at;
    int c2_at;
    int run_len [3];
    logic [2:0] d;
    logic [2:0] prev;
    for (int k = 0; k < 3; k++) begin
      st_pulses[k] = 0;
      st_min[k] = 1000000;
      st_max[k] = 0;
      run_len[k] = 0;
    end
    st_first = 3'b000;
    st_last_eject = -1;
    st_first_valve = -1;
    st_overlap = 1'b0;
    st_fault = 1'b0;
    run_done = 1'b0;
    c1_at = -1;
    c2_at = -1;
    prev = 3'b000;
    c = 0;
    while (!run_done && c < budget) begin
      step({1'b0, pw_0 && (c == 0), c < n_c1, c2_0 && (c == 0),
            c22_0 && (c == 0), c == c1_at, c == c2_at});
      d = {eject1, eject2, valve_open};
      if ($countones(d) > 1) st_overlap = 1'b1;
      if (st_first == 3'b000) st_first = d;
      if (d[2] || d[1]) st_last_eject = c;
      if (d[0] && st_first_valve < 0) st_first_valve = c;
      if (fault) st_fault = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (d[k]) begin
          run_len[k]++;
        end else if (prev[k]) begin
          st_pulses[k]++;
          if (run_len[k] < st_min[k]) st_min[k] = run_len[k];
          if (run_len[k] > st_max[k]) st_max[k] = run_len[k];
          run_len[k] = 0;
          if (k == 2) c1_at = c + delay;
          if (k == 1) c2_at = c + delay;
        end
      end
      if (c >= 1 && !busy) run_done = 1'b1;
      prev = d;
      c++;
    end
  endtask

  logic [5:0] o;
  logic bad_valve, bad_busy, bad_fault;

  initial begin
    {reset, pour_water, change1, change2, change22, coin1_seen, coin2_seen} = IN_RST;

    // Single 1-coin change timeline: pulse cycles 2-9, coin at 12, GAP 13-16.
    for (int i = 0; i < 19; i++) begin
      logic e1;
      logic bz;
      tv[i].in = IN_NONE;
      if (i == 0) tv[i].in = IN_C1;
      if (i == 12) tv[i].in = IN_S1;
      e1 = (i >= 2) && (i <= 9);
      bz = (i >= 1) && (i <= 16);
      tv[i].exp = {e1, 1'b0, 1'b0, bz, 1'b0, 1'b0};
    end

    // Reset held while requests toggle.
    step(IN_RST | IN_C1 | IN_POUR);
    chk_vec("reset_cyc0", outs(), 6'b000000);
    step(IN_RST | IN_C2 | 7'b0000100);
    chk_vec("reset_cyc1", outs(), 6'b000000);
    for (int i = 0; i < 5; i++) step(IN_NONE);
    chk_vec("reset_idle_after", outs(), 6'b000000);

    for (int i = 0; i < 19; i++) begin
      step(tv[i].in);
      chk_vec($sformatf("single_c1_cyc%0d", i), outs(), tv[i].exp);
    end

    // change22 + pour together.
    do_reset();
    run_seq(0, 1'b0, 1'b1, 1'b1, 1, 400);
    chk("t3_done", run_done, 1);
    chk("t3_eject2_pulses", st_pulses[1], 2);
    chk("t3_eject2_min_len", st_min[1], 8);
    chk("t3_eject2_max_len", st_max[1], 8);
    chk("t3_eject1_pulses", st_pulses[2], 0);
    chk("t3_valve_pulses", st_pulses[0], 1);
    chk("t3_valve_len", st_max[0], 100);
    chk("t3_overlap", st_overlap, 0);
    chk("t3_valve_after_ejects", st_first_valve > st_last_eject, 1);
    chk("t3_fault", st_fault, 0);
    chk("t3_overflow", overflow, 0);

    // Priority: 2-coin wins over 1-coin requested the same cycle.
    do_reset();
    run_seq(1, 1'b1, 1'b0, 1'b0, 1, 200);
    chk("prio_first_drive", st_first, 3'b010);
    chk("prio_eject1_pulses", st_pulses[2], 1);
    chk("prio_eject2_pulses", st_pulses[1], 1);
    chk("prio_done", run_done, 1);

    // Missing coin: WAIT2 cycles 10-73, FAULT from 74.
    do_reset();
    step(IN_C2);
    for (int c = 1; c <= 73; c++) begin
      step(IN_NONE);
      if (c == 1) chk_vec("miss_cyc1", outs(), 6'b000100);
      if (c == 2) chk_vec("miss_cyc2", outs(), 6'b010100);
      if (c == 10) chk_vec("miss_cyc10", outs(), 6'b000100);
    end
    chk_vec("miss_cyc73", outs(), 6'b000100);
    step(IN_NONE);
    chk_vec("miss_cyc74_fault", outs(), 6'b000110);
    step(IN_POUR);
    bad_valve = 1'b0;
    bad_busy = 1'b0;
    bad_fault = 1'b0;
    for (int c = 0; c < 110; c++) begin
      step(IN_NONE);
      if (valve_open || eject1 || eject2) bad_valve = 1'b1;
      if (!busy) bad_busy = 1'b1;
      if (!fault) bad_fault = 1'b1;
    end
    chk("fault_no_drive", bad_valve, 0);
    chk("fault_busy_held", bad_busy, 0);
    chk("fault_sticky", bad_fault, 0);
    do_reset();
    chk_vec("fault_cleared_by_reset", outs(), 6'b000000);

    // Coin in the final timeout cycle is still accepted.
    step(IN_C2);
    for (int c = 1; c <= 72; c++) step(IN_NONE);
    step(IN_S2);
    step(IN_NONE);
    chk_vec("late_coin_cyc74", outs(), 6'b000100);
    step(IN_NONE);
    step(IN_NONE);
    step(IN_NONE);
    chk_vec("late_coin_cyc77", outs(), 6'b000100);
    step(IN_NONE);
    chk_vec("late_coin_cyc78", outs(), 6'b000000);

    // Saturation: 16 change1 strobes, confirmations held off past the burst.
    do_reset();
    run_seq(16, 1'b0, 1'b0, 1'b0, 8, 800);
    chk("sat_done", run_done, 1);
    chk("sat_eject1_pulses", st_pulses[2], 15);
    chk("sat_eject1_len", st_max[2], 8);
    chk("sat_overflow", overflow, 1);
    chk("sat_fault", st_fault, 0);
    do_reset();
    chk("sat_overflow_cleared", overflow, 0);

    // Reset in the 50th POUR cycle (cycle 51) with a second pour pending.
    step(IN_POUR);
    step(IN_POUR);
    chk("pour_cyc1_valve", valve_open, 0);
    step(IN_NONE);
    chk("pour_cyc2_valve", valve_open, 1);
    for (int c = 3; c <= 50; c++) step(IN_NONE);
    step(IN_RST);
    chk("pour_cyc51_valve", valve_open, 1);
    step(IN_NONE);
    chk_vec("pour_cyc52_after_reset", outs(), 6'b000000);
    for (int c = 0; c < 10; c++) step(IN_NONE);
    chk_vec("pour_idle_after_reset", outs(), 6'b000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
